// File: rtl/wimax_pkg.sv
// Shared WiMAX PHY transmit constants and types for the burst sequencer and randomizer.
package wimax_pkg;

    localparam int BLOCK_BITS = 96;
    localparam int MAX_BLOCKS = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        DONE
    } tx_ctrl_state_t;

    typedef struct packed {
        logic block_last;
        logic burst_last;
    } beat_flags_t;

endpackage

// File: rtl/wimax_tx_ctrl.sv
// Burst sequencer: seeds the randomizer once per burst and turns its output into a valid/ready stream.
// Optional abort input is built when WIMAX_TX_CTRL_ABORT_EN is defined.
module wimax_tx_ctrl #(
    parameter int BLOCK_BITS = wimax_pkg::BLOCK_BITS,
    parameter int MAX_BLOCKS = wimax_pkg::MAX_BLOCKS
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [$clog2(MAX_BLOCKS+1)-1:0]   num_blocks,
    output logic                              busy,
    output logic                              done,
    input  logic                              src_valid,
    output logic                              src_ready,
    output logic                              prbs_load,
    output logic                              prbs_en,
    output logic                              prbs_i_valid,
    input  logic                              prbs_o_data,
    output logic                              fec_valid,
    output logic                              fec_data,
    output logic                              fec_block_last,
    output logic                              fec_burst_last,
    input  logic                              fec_ready
`ifdef WIMAX_TX_CTRL_ABORT_EN
    ,
    input  logic                              abort
`endif
);
    import wimax_pkg::*;

    localparam int NB_W  = $clog2(MAX_BLOCKS+1);
    localparam int BIT_W = $clog2(BLOCK_BITS);
    localparam logic [NB_W-1:0]  MAX_NB   = NB_W'(MAX_BLOCKS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BLOCK_BITS-1);

    tx_ctrl_state_t    state;
    logic [BIT_W-1:0]  bit_cnt;
    logic [NB_W-1:0]   blk_cnt;
    logic [NB_W-1:0]   nblk;
    beat_flags_t       flags;
    logic              accept;
    logic              last_bit;
    logic              last_blk;
    logic              abort_hit;

`ifdef WIMAX_TX_CTRL_ABORT_EN
    assign abort_hit = abort & ((state == LOAD) | (state == RUN) | (state == DRAIN));
`else
    assign abort_hit = 1'b0;
`endif

    // A stalled beat blocks the randomizer so its held o_data stays aligned with the beat.
    assign src_ready    = (state == RUN) & (~fec_valid | fec_ready) & ~abort_hit;
    assign prbs_en      = src_ready;
    assign accept       = src_valid & src_ready;
    assign prbs_i_valid = accept;

    assign last_bit = (bit_cnt == LAST_BIT);
    assign last_blk = (blk_cnt == nblk - NB_W'(1));

    assign fec_data       = prbs_o_data;
    assign fec_block_last = flags.block_last;
    assign fec_burst_last = flags.burst_last;

    // done is registered from DONE, so it lands one cycle after the state is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            prbs_load <= 1'b0;
            nblk      <= '0;
        end else begin
            done      <= (state == DONE);
            prbs_load <= 1'b0;
            if (abort_hit) begin
                state <= DONE;
                busy  <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            nblk <= (num_blocks > MAX_NB) ? MAX_NB : num_blocks;
                            busy <= 1'b1;
                            if (num_blocks == '0) begin
                                state <= DONE;
                            end else begin
                                state     <= LOAD;
                                prbs_load <= 1'b1;
                            end
                        end
                    end
                    LOAD:  state <= RUN;
                    RUN:   if (accept && last_bit && last_blk) state <= DRAIN;
                    DRAIN: if (!fec_valid || fec_ready) state <= DONE;
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            blk_cnt <= '0;
        end else if (state == LOAD || abort_hit) begin
            bit_cnt <= '0;
            blk_cnt <= '0;
        end else if (accept) begin
            if (last_bit) begin
                bit_cnt <= '0;
                blk_cnt <= blk_cnt + NB_W'(1);
            end else begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fec_valid <= 1'b0;
            flags     <= '0;
        end else if (abort_hit) begin
            fec_valid <= 1'b0;
        end else if (accept) begin
            fec_valid        <= 1'b1;
            flags.block_last <= last_bit;
            flags.burst_last <= last_bit & last_blk;
        end else if (fec_ready) begin
            fec_valid <= 1'b0;
        end
    end

endmodule
